// File: rtl/z80_bus_pkg.sv
// Shared types and constants for the Z80 bus companion and its interrupt controller.
// Wait-state counter width bounds MEM_WAIT/IO_WAIT to 0..15.
package z80_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } wait_state_e;

    localparam logic [7:0] ACK_SPURIOUS = 8'hFF;
    localparam int         WCNT_W       = 4;

endpackage

// File: rtl/z80_bus_ctrl_if.sv
// CPU-side strobes, interrupt lines and acknowledge vector between the T80 wrapper and z80_bus_ctrl.
// master = CPU wrapper / board side, slave = bus controller.
interface z80_bus_ctrl_if #(
    parameter int N_IRQ = 4
);
    logic             CPU_MREQ_N;
    logic             CPU_IORQ_N;
    logic             CPU_M1_N;
    logic             CPU_RD_N;
    logic             CPU_WR_N;
    logic             EXT_WAIT_N;
    logic             CPU_CEN;
    logic             CPU_WAIT_N;
    logic             CPU_INT_N;
    logic [N_IRQ-1:0] IRQ_REQ;
    logic [N_IRQ-1:0] IRQ_MASK;
    logic [N_IRQ-1:0] IRQ_PEND;
    logic [7:0]       ACK_DATA;
    logic             ACK_OE;

    modport master (
        output CPU_MREQ_N, CPU_IORQ_N, CPU_M1_N, CPU_RD_N, CPU_WR_N, EXT_WAIT_N,
        output IRQ_REQ, IRQ_MASK,
        input  CPU_CEN, CPU_WAIT_N, CPU_INT_N, IRQ_PEND, ACK_DATA, ACK_OE
    );

    modport slave (
        input  CPU_MREQ_N, CPU_IORQ_N, CPU_M1_N, CPU_RD_N, CPU_WR_N, EXT_WAIT_N,
        input  IRQ_REQ, IRQ_MASK,
        output CPU_CEN, CPU_WAIT_N, CPU_INT_N, IRQ_PEND, ACK_DATA, ACK_OE
    );
endinterface

// File: rtl/z80_irq_ctrl.sv
// N-source interrupt controller: 2-flop sync, rising-edge pending latches, priority encode, IM2 ack.
// Latency: request edge -> pending 3 CLK, INT_N 1 CLK after pending; vector valid 1 CLK after ack start.
// Backpressure: none; ack held until IORQ_N rises. Vectors only with Z80_BUS_IM2_VECTOR_EN.
module z80_irq_ctrl
    import z80_bus_pkg::*;
#(
    parameter int         N_IRQ    = 4,
    parameter logic [7:0] VEC_BASE = 8'hE0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IRQ-1:0] irq_req,
    input  logic [N_IRQ-1:0] irq_mask,
    input  logic             m1_n,
    input  logic             iorq_n,
    output logic [N_IRQ-1:0] irq_pend,
    output logic             int_n,
    output logic [7:0]       ack_data,
    output logic             ack_oe
);

    logic [N_IRQ-1:0] sync1_q, sync2_q, sync3_q;
    logic [N_IRQ-1:0] pend_q, pend_d, active, clr;
    logic             int_n_q, int_n_d;
    logic             ack_oe_q, ack_oe_d;
    logic             hit_q, hit_d;
    logic [2:0]       idx_q, idx_d;
    logic [2:0]       enc_idx;
    logic             enc_hit;
    logic             ack;

    assign active = pend_q & irq_mask;
    assign ack    = ~m1_n & ~iorq_n;

    // Lowest index wins: scan downwards so the last assignment is the lowest set bit.
    always_comb begin
        enc_hit = 1'b0;
        enc_idx = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (active[i]) begin
                enc_hit = 1'b1;
                enc_idx = 3'(i);
            end
        end
    end

    always_comb begin
        ack_oe_d = ack_oe_q;
        hit_d    = hit_q;
        idx_d    = idx_q;
        clr      = '0;
        if (!ack_oe_q && ack) begin
            ack_oe_d = 1'b1;
            hit_d    = enc_hit;
            idx_d    = enc_idx;
        end else if (ack_oe_q && iorq_n) begin
            ack_oe_d = 1'b0;
            hit_d    = 1'b0;
            for (int i = 0; i < N_IRQ; i++) begin
                clr[i] = hit_q && (idx_q == 3'(i));
            end
        end
        // A fresh edge landing in the clearing cycle keeps the source pending.
        pend_d  = (pend_q & ~clr) | (sync2_q & ~sync3_q);
        int_n_d = ~|active;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            sync3_q  <= '0;
            pend_q   <= '0;
            int_n_q  <= 1'b1;
            ack_oe_q <= 1'b0;
            hit_q    <= 1'b0;
            idx_q    <= '0;
        end else begin
            sync1_q  <= irq_req;
            sync2_q  <= sync1_q;
            sync3_q  <= sync2_q;
            pend_q   <= pend_d;
            int_n_q  <= int_n_d;
            ack_oe_q <= ack_oe_d;
            hit_q    <= hit_d;
            idx_q    <= idx_d;
        end
    end

`ifdef Z80_BUS_IM2_VECTOR_EN
    logic [7:0] ack_data_q, ack_data_d;

    always_comb begin
        ack_data_d = ack_data_q;
        if (!ack_oe_q && ack) begin
            ack_data_d = enc_hit ? (VEC_BASE + 8'({enc_idx, 1'b0})) : ACK_SPURIOUS;
        end else if (ack_oe_q && iorq_n) begin
            ack_data_d = ACK_SPURIOUS;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_data_q <= ACK_SPURIOUS;
        end else begin
            ack_data_q <= ack_data_d;
        end
    end

    assign ack_data = ack_data_q;
`else
    // IM0/IM1 build: all-ones OR'd with the base is always 8'hFF (RST 38h).
    assign ack_data = ACK_SPURIOUS | VEC_BASE;
`endif

    assign irq_pend = pend_q;
    assign int_n    = int_n_q;
    assign ack_oe   = ack_oe_q;

endmodule

// File: rtl/z80_bus_ctrl.sv
// Z80 bus companion: CPU clock enable, MEM/IO wait-state insertion, interrupt controller (opt Z80_BUS_IM2_VECTOR_EN).
// Latency: CEN registered; WAIT_N drops one CEN after a strobe is seen; EXT_WAIT_N is combinational.
// Backpressure: WAIT_N stalls the CPU for exactly MEM_WAIT/IO_WAIT CEN periods per access.
module z80_bus_ctrl
    import z80_bus_pkg::*;
#(
    parameter int         CLK_DIV  = 4,
    parameter int         MEM_WAIT = 0,
    parameter int         IO_WAIT  = 1,
    parameter int         N_IRQ    = 4,
    parameter logic [7:0] VEC_BASE = 8'hE0
) (
    input logic           CLK,
    input logic           RESET_N,
    z80_bus_ctrl_if.slave bus
);

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0]  div_q, div_d;
    logic              cen_q, cen_d;
    wait_state_e       state_q, state_d;
    logic [WCNT_W-1:0] cnt_q, cnt_d;
    logic              mem_acc, io_acc;

    assign mem_acc = ~bus.CPU_MREQ_N & (~bus.CPU_RD_N | ~bus.CPU_WR_N);
    assign io_acc  = ~bus.CPU_IORQ_N & bus.CPU_M1_N;

    always_comb begin
        cen_d = (div_q == DIV_LAST);
        div_d = cen_d ? '0 : div_q + DIV_W'(1);
    end

    // Refresh (MREQ without RD/WR) and IM2 ack (IORQ with M1) never start a wait.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (cen_q) begin
            case (state_q)
                IDLE: begin
                    if (mem_acc) begin
                        cnt_d   = WCNT_W'(MEM_WAIT);
                        state_d = (MEM_WAIT != 0) ? WAIT : DONE;
                    end else if (io_acc) begin
                        cnt_d   = WCNT_W'(IO_WAIT);
                        state_d = (IO_WAIT != 0) ? WAIT : DONE;
                    end
                end
                WAIT: begin
                    cnt_d = cnt_q - WCNT_W'(1);
                    if (cnt_q == WCNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (bus.CPU_MREQ_N && bus.CPU_IORQ_N) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            div_q   <= '0;
            cen_q   <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            div_q   <= div_d;
            cen_q   <= cen_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.CPU_CEN    = cen_q;
    assign bus.CPU_WAIT_N = (state_q != WAIT) & bus.EXT_WAIT_N;

    z80_irq_ctrl #(
        .N_IRQ    (N_IRQ),
        .VEC_BASE (VEC_BASE)
    ) u_irq (
        .clk      (CLK),
        .rst_n    (RESET_N),
        .irq_req  (bus.IRQ_REQ),
        .irq_mask (bus.IRQ_MASK),
        .m1_n     (bus.CPU_M1_N),
        .iorq_n   (bus.CPU_IORQ_N),
        .irq_pend (bus.IRQ_PEND),
        .int_n    (bus.CPU_INT_N),
        .ack_data (bus.ACK_DATA),
        .ack_oe   (bus.ACK_OE)
    );

endmodule
